// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the branch predictor: BTB entry layout,
// index/tag widths and direction-counter constants.
package bp_pkg;

  localparam int ADDR_W    = 32;
  localparam int TAG_MAX_W = 30;
  localparam int CNT_MAX_W = 4;

  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_width(input int entries);
    return ADDR_W - 2 - $clog2(entries);
  endfunction

  function automatic logic [CNT_MAX_W-1:0] cnt_reset_val(input int cnt_bits);
    return CNT_MAX_W'((1 << (cnt_bits - 1)) - 1);
  endfunction

  function automatic logic [CNT_MAX_W-1:0] cnt_alloc_val(input int cnt_bits);
    return CNT_MAX_W'(1 << (cnt_bits - 1));
  endfunction

  function automatic logic [CNT_MAX_W-1:0] cnt_max_val(input int cnt_bits);
    return CNT_MAX_W'((1 << cnt_bits) - 1);
  endfunction

  // Tag and counter fields are sized for the widest configuration; narrower
  // builds keep the upper bits at zero.
  typedef struct packed {
    logic                 v;
    logic [TAG_MAX_W-1:0] tag;
    logic [ADDR_W-1:0]    target;
    logic [CNT_MAX_W-1:0] cnt;
    logic                 is_ret;
  } btb_entry_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack trained at branch resolution; pop-then-push
// in the same cycle replaces the top. Used only when BP_RAS_EN is defined.
module return_addr_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_addr_i,
  output logic [31:0] top_o,
  output logic        nonempty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   stack_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, pop_ptr_s;
  logic [CW-1:0] cnt_q, cnt_d, pop_cnt_s;
  logic          wr_s;

  // Apply the pop first, then the push on the post-pop pointer.
  always_comb begin
    pop_ptr_s = ptr_q;
    pop_cnt_s = cnt_q;
    wr_s      = 1'b0;
    if (pop_i && (cnt_q != CW'(0))) begin
      pop_ptr_s = ptr_q - PW'(1);
      pop_cnt_s = cnt_q - CW'(1);
    end else begin
      pop_ptr_s = ptr_q;
      pop_cnt_s = cnt_q;
    end
    if (push_i) begin
      wr_s  = 1'b1;
      ptr_d = pop_ptr_s + PW'(1);
      cnt_d = (pop_cnt_s == CW'(DEPTH)) ? pop_cnt_s : pop_cnt_s + CW'(1);
    end else begin
      ptr_d = pop_ptr_s;
      cnt_d = pop_cnt_s;
    end
  end

  // Stack storage, pointer and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 32'd0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_s) stack_q[pop_ptr_s] <= push_addr_i;
    end
  end

  assign top_o      = stack_q[ptr_q - PW'(1)];
  assign nonempty_o = (cnt_q != CW'(0));

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with saturating direction counters; combinational
// lookup, one EX-stage update per cycle. Optional RAS under `BP_RAS_EN`.
import bp_pkg::*;

module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] target_pc,
  output logic        valid,
  output logic        predicted_taken,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_call,
  input  logic        update_ret
);

  localparam int IDX = idx_width(ENTRIES);
  localparam logic [CNT_MAX_W-1:0] CNT_RST   = cnt_reset_val(CNT_BITS);
  localparam logic [CNT_MAX_W-1:0] CNT_ALLOC = cnt_alloc_val(CNT_BITS);
  localparam logic [CNT_MAX_W-1:0] CNT_MAX   = cnt_max_val(CNT_BITS);

  btb_entry_t           btb_q [ENTRIES];
  btb_entry_t           lk_e_s, up_e_s, up_new_s;
  logic [IDX-1:0]       lk_idx_s, up_idx_s;
  logic [TAG_MAX_W-1:0] lk_tag_s, up_tag_s;
  logic                 lk_hit_s, up_hit_s, up_we_s;
  logic [31:0]          lk_tgt_s;

  assign lk_idx_s = pc[IDX+1:2];
  assign lk_tag_s = TAG_MAX_W'(pc[31:IDX+2]);
  assign up_idx_s = update_pc[IDX+1:2];
  assign up_tag_s = TAG_MAX_W'(update_pc[31:IDX+2]);
  assign lk_e_s   = btb_q[lk_idx_s];
  assign up_e_s   = btb_q[up_idx_s];
  assign lk_hit_s = lk_e_s.v && (lk_e_s.tag == lk_tag_s);
  assign up_hit_s = up_e_s.v && (up_e_s.tag == up_tag_s);

  // Next contents of the entry addressed by update_pc.
  always_comb begin
    up_new_s = up_e_s;
    up_we_s  = 1'b0;
    if (update && up_hit_s) begin
      up_we_s = 1'b1;
      if (update_taken) begin
        up_new_s.cnt    = (up_e_s.cnt != CNT_MAX) ? up_e_s.cnt + 4'd1 : up_e_s.cnt;
        up_new_s.target = update_target;
        up_new_s.is_ret = update_ret;
      end else begin
        up_new_s.cnt = (up_e_s.cnt != 4'd0) ? up_e_s.cnt - 4'd1 : up_e_s.cnt;
      end
    end else if (update && update_taken) begin
      up_we_s  = 1'b1;
      up_new_s = '{v: 1'b1, tag: up_tag_s, target: update_target,
                   cnt: CNT_ALLOC, is_ret: update_ret};
    end else begin
      up_we_s = 1'b0;
    end
  end

  // BTB storage; reset leaves every entry invalid and weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        btb_q[i] <= '{v: 1'b0, tag: '0, target: 32'd0, cnt: CNT_RST, is_ret: 1'b0};
    end else if (up_we_s) begin
      btb_q[up_idx_s] <= up_new_s;
    end
  end

`ifdef BP_RAS_EN
  logic [31:0] ras_top_s;
  logic        ras_nonempty_s;

  return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (update & update_call),
    .pop_i       (update & update_ret),
    .push_addr_i (update_pc + 32'd4),
    .top_o       (ras_top_s),
    .nonempty_o  (ras_nonempty_s)
  );

  assign lk_tgt_s = (lk_e_s.is_ret && ras_nonempty_s) ? ras_top_s : lk_e_s.target;
`else
  logic unused_s;
  assign unused_s = ^{lk_e_s.is_ret, update_call, RAS_DEPTH[0]};
  assign lk_tgt_s = lk_e_s.target;
`endif

  assign valid           = lk_hit_s;
  assign predicted_taken = lk_hit_s & lk_e_s.cnt[CNT_BITS-1];
  assign target_pc       = lk_hit_s ? lk_tgt_s : 32'd0;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_BITS=2,
// RAS_DEPTH=4); the RAS section runs only when BP_RAS_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, target_pc, update_pc, update_target;
  logic        valid, predicted_taken;
  logic        update, update_taken, update_call, update_ret;
  int          total = 0;
  int          bad   = 0;

  branch_predictor #(.ENTRIES(16), .CNT_BITS(2), .RAS_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .target_pc       (target_pc),
    .valid           (valid),
    .predicted_taken (predicted_taken),
    .update          (update),
    .update_pc       (update_pc),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .update_call     (update_call),
    .update_ret      (update_ret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] p, input logic ev,
                      input logic ept, input logic [31:0] et);
    pc = p;
    #1;
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    chk({tag, ".taken"}, {31'd0, predicted_taken}, {31'd0, ept});
    chk({tag, ".target"}, target_pc, et);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk,
                     input logic c, input logic r);
    @(negedge clk);
    update = 1'b1; update_pc = p; update_target = t;
    update_taken = tk; update_call = c; update_ret = r;
    @(posedge clk);
    #1;
    update = 1'b0; update_call = 1'b0; update_ret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h100; update = 1'b0; update_pc = 32'd0;
    update_target = 32'd0; update_taken = 1'b0; update_call = 1'b0; update_ret = 1'b0;
    #12;
    look("reset_hold", 32'h100, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    look("reset_miss", 32'h100, 1'b0, 1'b0, 32'd0);

    // Allocation: same-cycle lookup sees old contents, next cycle sees new.
    @(negedge clk);
    update = 1'b1; update_pc = 32'h100; update_target = 32'h200; update_taken = 1'b1;
    look("same_cycle", 32'h100, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    update = 1'b0;
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Two not-taken updates: 2 -> 1 -> 0; target untouched on not-taken.
    upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
    look("two_nt", 32'h100, 1'b1, 1'b0, 32'h200);

    // Saturation: five taken from 0 ends at 3; then 3 -> 2 (taken), 2 -> 1 (not).
    for (int i = 0; i < 5; i++) upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    look("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    look("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h200);

    // Not-taken miss allocates nothing.
    upd(32'h184, 32'h500, 1'b0, 1'b0, 1'b0);
    look("nt_miss", 32'h184, 1'b0, 1'b0, 32'd0);

    // Aliasing: 0x140 shares index 0 with 0x100 but has a different tag.
    upd(32'h140, 32'h300, 1'b1, 1'b0, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'd0);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Ret entry with empty stack yields its stored target.
    upd(32'h104, 32'h400, 1'b1, 1'b0, 1'b1);
    look("ret_stored", 32'h104, 1'b1, 1'b1, 32'h400);

`ifdef BP_RAS_EN
    upd(32'h208, 32'h900, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) upd(32'h10 * i, 32'h800, 1'b1, 1'b1, 1'b0);
    look("ras_pop0", 32'h208, 1'b1, 1'b1, 32'h54);
    upd(32'h208, 32'h900, 1'b1, 1'b0, 1'b1);
    look("ras_pop1", 32'h208, 1'b1, 1'b1, 32'h44);
    upd(32'h208, 32'h900, 1'b1, 1'b0, 1'b1);
    look("ras_pop2", 32'h208, 1'b1, 1'b1, 32'h34);
    upd(32'h208, 32'h900, 1'b1, 1'b0, 1'b1);
    look("ras_pop3", 32'h208, 1'b1, 1'b1, 32'h24);
    upd(32'h208, 32'h900, 1'b1, 1'b0, 1'b1);
    look("ras_empty", 32'h208, 1'b1, 1'b1, 32'h900);
`endif

    // Asynchronous reset between edges clears lookups immediately.
    @(posedge clk);
    #2;
    rst = 1'b1;
    look("async_rst_a", 32'h140, 1'b0, 1'b0, 32'd0);
    look("async_rst_b", 32'h104, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    look("post_rst", 32'h140, 1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
